// File: rtl/aes_pkg.sv
// Shared AES-128 constants, GF(2^8) helpers, S-box and round-controller state encoding.
package aes_pkg;

   localparam int unsigned NR      = 10;
   localparam int unsigned BLOCK_W = 128;
   localparam int unsigned COL_W   = 32;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned NCOL    = 4;
   localparam int unsigned NROW    = 4;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned FSM_W   = 3;

   localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(NR);

   localparam logic [FSM_W-1:0] S_IDLE     = 3'd0;
   localparam logic [FSM_W-1:0] S_ARK0     = 3'd1;
   localparam logic [FSM_W-1:0] S_SUBSHIFT = 3'd2;
   localparam logic [FSM_W-1:0] S_MIX      = 3'd3;
   localparam logic [FSM_W-1:0] S_ARK      = 3'd4;
   localparam logic [FSM_W-1:0] S_DONE     = 3'd5;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] s;
      p = 8'h00;
      s = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ s;
         s = xtime(s);
      end
      return p;
   endfunction

   // S-box as multiplicative inverse (x^254) followed by the AES affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns for one 32-bit column; byte r of the column at [8r +: 8].
module mix_single_column
   import aes_pkg::*;
(
   input  logic [COL_W-1:0] col,
   output logic [COL_W-1:0] mixed_c
);

   logic [BYTE_W-1:0] a0, a1, a2, a3;

   assign a0 = col[7:0];
   assign a1 = col[15:8];
   assign a2 = col[23:16];
   assign a3 = col[31:24];

   // 03*a is xtime(a)^a.
   assign mixed_c[7:0]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
   assign mixed_c[15:8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
   assign mixed_c[23:16] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
   assign mixed_c[31:24] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption round controller with a time-shared MixColumns column unit.
module aes_round_ctrl
   import aes_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BLOCK_W-1:0] in_data,
   output logic [IDX_W-1:0]   rk_idx,
   input  logic [BLOCK_W-1:0] rk_key,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BLOCK_W-1:0] out_data,
   output logic               busy
);

   logic [FSM_W-1:0]   fsm_q, fsm_d;
   logic [BLOCK_W-1:0] data_q, data_d;
   logic [IDX_W-1:0]   round_q, round_d;
   logic [1:0]         col_q, col_d;
   logic [IDX_W-1:0]   rk_idx_d;
   logic               in_ready_d, out_valid_d, busy_d;

   logic [BLOCK_W-1:0] subshift;
   logic [COL_W-1:0]   cur_col;
   logic [COL_W-1:0]   mix_c;

   assign out_data = data_q;

   // SubBytes and ShiftRows: output byte (r,c) takes S(input byte (r, c+r mod 4)).
   always_comb begin
      subshift = '0;
      for (int c = 0; c < NCOL; c++) begin
         for (int r = 0; r < NROW; r++) begin
            subshift[COL_W*c + BYTE_W*r +: BYTE_W] =
               sbox(data_q[COL_W*((c + r) % NCOL) + BYTE_W*r +: BYTE_W]);
         end
      end
   end

   assign cur_col = data_q[COL_W*32'(col_q) +: COL_W];

   mix_single_column u_mix (
      .col     (cur_col),
      .mixed_c (mix_c)
   );

   // Next-state, datapath and registered-output decode.
   always_comb begin
      fsm_d   = fsm_q;
      data_d  = data_q;
      round_d = round_q;
      col_d   = col_q;

      case (fsm_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               data_d  = in_data;
               round_d = 4'd1;
               fsm_d   = S_ARK0;
            end
         end
         S_ARK0: begin
            data_d = data_q ^ rk_key;
            fsm_d  = S_SUBSHIFT;
         end
         S_SUBSHIFT: begin
            data_d = subshift;
            if (round_q < LAST_ROUND) begin
               col_d = 2'd0;
               fsm_d = S_MIX;
            end else begin
               fsm_d = S_ARK;
            end
         end
         S_MIX: begin
            data_d[COL_W*32'(col_q) +: COL_W] = mix_c;
            col_d = col_q + 2'd1;
            if (col_q == 2'd3) fsm_d = S_ARK;
         end
         S_ARK: begin
            data_d = data_q ^ rk_key;
            if (round_q == LAST_ROUND) begin
               fsm_d = S_DONE;
            end else begin
               round_d = round_q + 4'd1;
               fsm_d   = S_SUBSHIFT;
            end
         end
         S_DONE: begin
            if (out_ready) fsm_d = S_IDLE;
         end
         default: fsm_d = S_IDLE;
      endcase

      // Key index is registered, so it is set on entry to the key-add state.
      rk_idx_d    = (fsm_d == S_ARK) ? round_d : 4'd0;
      in_ready_d  = (fsm_d == S_IDLE);
      out_valid_d = (fsm_d == S_DONE);
      busy_d      = (fsm_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q     <= S_IDLE;
         data_q    <= '0;
         round_q   <= 4'd1;
         col_q     <= 2'd0;
         rk_idx    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         fsm_q     <= fsm_d;
         data_q    <= data_d;
         round_q   <= round_d;
         col_q     <= col_d;
         rk_idx    <= rk_idx_d;
         in_ready  <= in_ready_d;
         out_valid <= out_valid_d;
         busy      <= busy_d;
      end
   end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: key-store model, scoreboard and latency monitor.
module tb_aes_round_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready;
   logic [127:0] in_data;
   logic [3:0]   rk_idx;
   logic [127:0] rk_key;
   logic         out_valid, out_ready;
   logic [127:0] out_data;
   logic         busy;

   logic [127:0] exp_ct;
   logic [127:0] rk_tab [0:10];
   logic [7:0]   sbox_t [0:255];

   int n_checks = 0;
   int n_fail   = 0;
   int edge_n   = 0;

   logic [127:0] sb_q [$];
   int           acc_q [$];
   logic         ov_prev = 1'b0;
   int           last_rise = -1;
   logic         b2b = 1'b0;

   always #5 clk = ~clk;

   aes_round_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .rk_idx    (rk_idx),
      .rk_key    (rk_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   assign rk_key = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : '0;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Polynomial multiply then reduce by 0x11B.
   function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] tb_sbox(input logic [7:0] x);
      logic [7:0] inv, s, c;
      inv = 8'h00;
      c   = 8'h63;
      for (int y = 1; y < 256; y++) if (tb_gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
         s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      return s;
   endfunction

   // FIPS hex string order -> byte i at bits [8i +: 8].
   function automatic logic [127:0] bswap(input logic [127:0] h);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = h[127-8*i -: 8];
      return o;
   endfunction

   task automatic load_keys(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {t[7:0], t[31:8]};
            t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {24'h0, rc};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int j = 0; j <= 10; j++) rk_tab[j] = {w[4*j+3], w[4*j+2], w[4*j+1], w[4*j]};
   endtask

   function automatic logic [3:0] exp_rk(input int e);
      if (e == 56) return 4'd10;
      if (e >= 6 && e <= 54 && (e % 6) == 0) return 4'(e / 6);
      return 4'd0;
   endfunction

   always @(posedge clk) edge_n <= edge_n + 1;

   // Scoreboard: push on accept, pop and compare on output handshake; latency on out_valid rise.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         acc_q.delete();
         ov_prev   <= 1'b0;
         last_rise <= -1;
      end else begin
         if (in_valid && in_ready) begin
            sb_q.push_back(exp_ct);
            acc_q.push_back(edge_n + 1);
         end
         if (out_valid && !ov_prev) begin
            if (acc_q.size() == 0) check("spurious_out_valid", 128'(1), 128'(0));
            else check("latency", 128'(edge_n - acc_q[0]), 128'(57));
            if (b2b && last_rise >= 0) check("b2b_spacing", 128'(edge_n - last_rise), 128'(59));
            last_rise <= b2b ? edge_n : -1;
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) check("unexpected_handshake", 128'(1), 128'(0));
            else begin
               check("ciphertext", out_data, sb_q.pop_front());
               void'(acc_q.pop_front());
            end
         end
         ov_prev <= out_valid;
      end
   end

   task automatic run_block(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] ct,
                            input int hold, input bit probe, input bit chk_rk);
      int e;
      int w;
      load_keys(key);
      w = 0;
      while (!in_ready && w < 20) begin step(); w++; end
      check("in_ready_wait", 128'(in_ready), 128'(1));
      in_data  = pt;
      exp_ct   = ct;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      e = 0;
      while (!out_valid && e < 100) begin
         if (chk_rk) check($sformatf("rk_idx_e%0d", e), 128'(rk_idx), 128'(exp_rk(e)));
         if (probe && e == 2)
            check("probe_after_shiftrows", dut.data_q,
                  {32'he598271e, 32'hf11141b8, 32'hae52b4e0, 32'h305dbfd4});
         if (probe && e == 3)
            check("probe_after_mix_col0", dut.data_q,
                  {32'he598271e, 32'hf11141b8, 32'hae52b4e0, 32'he5816604});
         step();
         e++;
      end
      check("out_valid_rise", 128'(out_valid), 128'(1));
      for (int h = 0; h < hold; h++) begin
         check("bp_out_data", out_data, ct);
         check("bp_in_ready", 128'(in_ready), 128'(0));
         check("bp_busy", 128'(busy), 128'(1));
         check("bp_out_valid", 128'(out_valid), 128'(1));
         in_valid = (h % 4 == 1);
         in_data  = {$urandom, $urandom, $urandom, $urandom};
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("post_in_ready", 128'(in_ready), 128'(1));
      check("post_out_valid", 128'(out_valid), 128'(0));
      check("post_busy", 128'(busy), 128'(0));
      check("post_out_data_hold", out_data, ct);
   endtask

   logic [127:0] key_b, pt_b, ct_b, key_c, pt_c, ct_c, ct_z;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog timeout");
   end

   initial begin
      int w;
      key_b = bswap(128'h2b7e151628aed2a6abf7158809cf4f3c);
      pt_b  = bswap(128'h3243f6a8885a308d313198a2e0370734);
      ct_b  = bswap(128'h3925841d02dc09fbdc118597196a0b32);
      key_c = bswap(128'h000102030405060708090a0b0c0d0e0f);
      pt_c  = bswap(128'h00112233445566778899aabbccddeeff);
      ct_c  = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      ct_z  = bswap(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
      for (int i = 0; i < 256; i++) sbox_t[i] = tb_sbox(8'(i));

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; exp_ct = '0;
      load_keys('0);
      repeat (3) step();
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_out_data", out_data, 128'(0));
      check("rst_rk_idx", 128'(rk_idx), 128'(0));
      rst = 1'b0;
      step();

      run_block(key_b, pt_b, ct_b, 0, 1'b1, 1'b0);
      run_block('0, '0, ct_z, 0, 1'b0, 1'b1);
      run_block(key_b, pt_b, ct_b, 20, 1'b0, 1'b0);

      // Abort mid-transaction: reset sampled on the 30th edge after accept.
      load_keys(key_b);
      in_data = pt_b; exp_ct = ct_b; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (29) step();
      check("pre_abort_busy", 128'(busy), 128'(1));
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_in_ready", 128'(in_ready), 128'(1));
      check("abort_out_valid", 128'(out_valid), 128'(0));
      check("abort_out_data", out_data, 128'(0));
      check("abort_busy", 128'(busy), 128'(0));
      run_block(key_c, pt_c, ct_c, 0, 1'b0, 1'b0);

      // Back-to-back with out_ready tied high; key store swapped once block 1 is finished.
      load_keys(key_b);
      b2b = 1'b1; out_ready = 1'b1;
      in_data = pt_b; exp_ct = ct_b; in_valid = 1'b1;
      step();
      in_data = pt_c; exp_ct = ct_c;
      w = 0;
      while (!out_valid && w < 100) begin step(); w++; end
      check("b2b_first_valid", 128'(out_valid), 128'(1));
      load_keys(key_c);
      w = 0;
      while (out_valid && w < 10) begin step(); w++; end
      w = 0;
      while (in_ready && w < 10) begin step(); w++; end
      in_valid = 1'b0;
      check("b2b_second_accept", 128'(in_ready), 128'(0));
      w = 0;
      while (!out_valid && w < 100) begin step(); w++; end
      check("b2b_second_valid", 128'(out_valid), 128'(1));
      step();
      out_ready = 1'b0;
      b2b = 1'b0;
      step();
      check("b2b_idle", 128'(in_ready), 128'(1));
      check("sb_drained", 128'(sb_q.size()), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
